// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four byte requesters share one UART transmitter,
// with a start timeout that flags a transmitter which never goes busy.
module uart_tx_arbiter #(
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_busy,
  output logic [1:0]  grant_id,
  output logic        active,
  input  logic        err_clr,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t     state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic [1:0] last_grant, winner, idx;
  logic       found, grant, timeout;

  // Search starts one past the last winner; the final step (offset 4) revisits it.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    idx    = last_grant;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && found) begin
          grant     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == 5'(START_TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= 2'd3;
      tx_en       <= 1'b0;
      req_ready   <= '0;
      tx_data     <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tx_en     <= grant;
      req_ready <= grant ? (4'b0001 << winner) : 4'b0000;
      if (grant) begin
        tx_data    <= req_data[{winner, 3'b000} +: 8];
        grant_id   <= winner;
        last_grant <= winner;
      end
      // A timeout on the same edge as err_clr keeps the flag set.
      if (timeout) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues plus a transmitter model
// drive the DUT; a round-robin reference predicts the (id, byte) grant sequence.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_clr;
  logic        timeout_err;

  logic        ext_busy;
  logic        mdl_busy;
  int          xmode;      // 0: normal transmitter, 1: never busy, 2: busy driven by test
  int          dur;
  int          busy_left;

  logic [7:0]  rq [4][$];
  logic [9:0]  expq [$];
  logic [9:0]  mon_e;
  int unsigned mlast;
  int          ten_count = 0;
  int          total = 0;
  int          bad = 0;

  assign tx_busy = (xmode == 2) ? ext_busy : mdl_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.START_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .err_clr(err_clr), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: drain the loaded queues in round-robin order from the model's last winner.
  function automatic void predict();
    logic [7:0] c [4][$];
    int unsigned left = 0;
    for (int i = 0; i < 4; i++) begin
      c[i] = rq[i];
      left += c[i].size();
    end
    while (left > 0) begin
      int unsigned id = 0;
      bit hit = 0;
      for (int unsigned k = 1; k <= 4; k++) begin
        if (!hit && c[(mlast + k) % 4].size() > 0) begin
          id  = (mlast + k) % 4;
          hit = 1;
        end
      end
      expq.push_back({2'(id), c[id].pop_front()});
      mlast = id;
      left--;
    end
  endfunction

  // Requesters and transmitter model, updated just after each rising edge.
  initial begin
    req_valid = '0;
    req_data  = '0;
    mdl_busy  = 1'b0;
    busy_left = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        req_valid[i]        = (rq[i].size() > 0);
        req_data[8*i +: 8]  = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
      end
      if (busy_left > 0) begin
        mdl_busy = 1'b1;
        busy_left--;
      end else begin
        mdl_busy = 1'b0;
      end
      if (tx_en && xmode == 0) busy_left = dur;
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on each send trigger.
  always @(negedge clk) begin
    check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
    check("ready_with_en", 32'(req_ready != 4'b0000), 32'(tx_en));
    if (tx_en) begin
      ten_count++;
      if (expq.size() == 0) begin
        check("unexpected_grant", {22'd0, grant_id, tx_data}, 32'h3ff);
      end else begin
        mon_e = expq.pop_front();
        check("grant_id", 32'(grant_id), 32'(mon_e[9:8]));
        check("tx_data", 32'(tx_data), 32'(mon_e[7:0]));
        check("req_ready", 32'(req_ready), 32'(4'b0001 << mon_e[9:8]));
      end
    end
  end

  task automatic wait_tx_en(input int maxcyc);
    bit seen = 0;
    for (int n = 0; n < maxcyc && !seen; n++) begin
      @(negedge clk);
      if (tx_en) seen = 1;
    end
    check("tx_en_seen", 32'(seen), 1);
  endtask

  task automatic wait_drain(input int maxcyc);
    bit done = 0;
    for (int n = 0; n < maxcyc && !done; n++) begin
      @(negedge clk);
      if (expq.size() == 0 && !active && !tx_busy &&
          rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0)
        done = 1;
    end
    check("drain", 32'(done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_en"}, 32'(tx_en), 0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_grant_id"}, 32'(grant_id), 0);
    check({tag, "_active"}, 32'(active), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mlast = 3;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b1; err_clr = 1'b0; xmode = 0; ext_busy = 1'b0; dur = 1; mlast = 3;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single request, long busy
    dur = 20;
    c0 = ten_count;
    rq[0].push_back(8'hA5);
    predict();
    wait_tx_en(20);
    repeat (10) begin
      @(negedge clk);
      check("active_while_busy", 32'(active), 1);
    end
    wait_drain(100);
    check("single_tx_en_count", 32'(ten_count - c0), 1);
    check("tx_data_held", 32'(tx_data), 32'hA5);
    check("grant_id_held", 32'(grant_id), 0);

    // All four requesters pending from reset
    do_reset();
    dur = 2;
    rq[0].push_back(8'h10); rq[0].push_back(8'h10);
    rq[1].push_back(8'h21); rq[2].push_back(8'h32); rq[3].push_back(8'h43);
    predict();
    wait_drain(200);

    // Transmitter held busy externally
    @(negedge clk);
    xmode = 2; ext_busy = 1'b1;
    c0 = ten_count;
    rq[2].push_back(8'h5C);
    predict();
    repeat (10) @(negedge clk);
    check("no_grant_while_busy", 32'(ten_count - c0), 0);
    ext_busy = 1'b0; xmode = 0;
    @(posedge clk);
    #1;
    check("grant_after_busy_en", 32'(tx_en), 1);
    check("grant_after_busy_id", 32'(grant_id), 2);
    wait_drain(100);

    // Start timeout, then err_clr, then err_clr coincident with timeout
    xmode = 1;
    rq[0].push_back(8'h5A);
    predict();
    wait_tx_en(20);
    repeat (15) @(negedge clk);
    check("timeout_not_yet", 32'(timeout_err), 0);
    check("active_before_timeout", 32'(active), 1);
    @(negedge clk);
    check("timeout_set", 32'(timeout_err), 1);
    check("idle_after_timeout", 32'(active), 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("timeout_cleared", 32'(timeout_err), 0);
    rq[1].push_back(8'h6B);
    predict();
    wait_tx_en(20);
    repeat (15) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("timeout_set_wins", 32'(timeout_err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("timeout_cleared2", 32'(timeout_err), 0);
    wait_drain(100);

    // Reset during WAIT_DONE
    xmode = 0; dur = 8;
    rq[3].push_back(8'h77);
    predict();
    wait_tx_en(20);
    repeat (3) @(negedge clk);
    check("in_transfer", 32'(active), 1);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    mlast = 3;
    rq[1].push_back(8'h11);
    rq[3].push_back(8'h33);
    predict();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tx_en(40);
    check("first_after_reset", 32'(grant_id), 1);
    wait_drain(200);

    // Randomized traffic
    for (int r = 0; r < 20; r++) begin
      @(negedge clk);
      dur = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        int n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) rq[i].push_back(8'($urandom));
      end
      predict();
      wait_drain(400);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter START_TIMEOUT, default 16, giving the max cycles to wait for tx_busy to rise after a tx_en pulse; legal range 2..31.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  4  per-requester byte-pending flag; bit i = requester i.
REQ-005 SHALL have port req_data  input  32  requester i byte on bits [8i+7:8i]; held stable while req_valid[i]=1 until req_ready[i].
REQ-006 SHALL have port req_ready  output  4  one-cycle acceptance pulse; at most one bit high per cycle.
REQ-007 SHALL have port tx_data  output  8  byte to transmitter data input; registered.
REQ-008 SHALL have port tx_en  output  1  one-cycle send trigger to transmitter.
REQ-009 SHALL have port tx_busy  input  1  transmitter busy flag.
REQ-010 SHALL have port grant_id  output  2  index of requester currently owning the transmitter.
REQ-011 SHALL have port active  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port err_clr  input  1  clears timeout_err.
REQ-013 SHALL have port timeout_err  output  1  sticky flag: transmitter failed to start.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT_BUSY, WAIT_DONE.
REQ-015 SHALL, in IDLE with tx_busy=0 and any req_valid bit set, select one winner by round-robin: search starts at last_grant+1 mod 4, wraps, first set bit wins.
REQ-016 SHALL, on that grant edge: register tx_data from winner's req_data slice, grant_id=winner, last_grant=winner, drive tx_en=1 and req_ready[winner]=1 for exactly the next cycle, clear wait counter, enter WAIT_BUSY.
REQ-017 SHALL not grant in IDLE while tx_busy=1; requests remain pending, no ready pulses.
REQ-018 SHALL, in WAIT_BUSY, go to WAIT_DONE on first cycle tx_busy=1 sampled.
REQ-019 SHALL, in WAIT_BUSY, increment a 5-bit counter each cycle tx_busy=0; when counter reaches START_TIMEOUT-1 with tx_busy still 0, set timeout_err=1 and return to IDLE (byte dropped; already acknowledged).
REQ-020 SHALL, in WAIT_DONE, return to IDLE on first cycle tx_busy=0 sampled; new grant possible no earlier than the following edge.
REQ-021 SHALL keep tx_data and grant_id unchanged from grant until next grant.
REQ-022 SHALL drive tx_en and req_ready low in every cycle except the single cycle after a grant edge.
REQ-023 SHALL ignore req_valid changes outside IDLE; a requester dropping valid before ready is not an error and simply loses arbitration.
REQ-024 SHALL clear timeout_err on err_clr=1; if timeout set and err_clr occur same edge, set wins (timeout_err=1).
REQ-025 SHALL give minimum grant-to-grant spacing of 3 cycles + transmitter busy duration.

Reset
REQ-026 SHALL, while rst_n=0, force immediately (asynchronously): state=IDLE, tx_en=0, req_ready=0, tx_data=0x00, grant_id=0, active=0, timeout_err=0, counter=0, last_grant=3 (requester 0 first priority).
REQ-027 SHALL, on reset mid-transfer, abandon the transfer with no further tx_en or req_ready pulses; first grant after rst_n rises follows REQ-015 with last_grant=3.

Verification
REQ-028 Single request: req_valid=0001, req_data[7:0]=0xA5, transmitter model busy 1 cycle after tx_en for 20 cycles -> tx_data=0xA5, one tx_en pulse, req_ready=0001 once, grant_id=0, active high until busy falls.
REQ-029 All four valid continuously, data 0x10/0x21/0x32/0x43 -> grant order 0,1,2,3,0; tx_data sequence 0x10,0x21,0x32,0x43,0x10; never two req_ready bits simultaneously.
REQ-030 tx_busy held 1 externally, req_valid=0100 -> no tx_en/req_ready until tx_busy drops; then grant_id=2 on next edge.
REQ-031 Transmitter model never asserts busy, START_TIMEOUT=16 -> timeout_err=1 exactly 16 cycles after tx_en cycle, FSM IDLE; err_clr pulse -> timeout_err=0; err_clr coincident with timeout -> timeout_err=1.
REQ-032 rst_n low during WAIT_DONE -> all outputs at REQ-026 values same cycle; after release with req_valid=1010 -> requester 1 granted first.
